// File: rtl/tiny_cpu_param_if.sv
// Instruction/result bus for tiny_cpu_param: valid/ready instruction input plus
// result register, flags and status pulses back to the consumer.
interface tiny_cpu_param_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
);
    localparam int RB = $clog2(NREGS);
    localparam int IW = 4 + 2*RB + WIDTH;

    logic [IW-1:0]    In;
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] Result;
    logic             Res_valid;
    logic             Zero;
    logic             Carry;
    logic             Err;

    modport master (
        output In, In_valid,
        input  In_ready, Result, Res_valid, Zero, Carry, Err
    );

    modport slave (
        input  In, In_valid,
        output In_ready, Result, Res_valid, Zero, Carry, Err
    );
endinterface

// File: rtl/tiny_cpu_param.sv
// Parametrised tiny CPU: NREGS x WIDTH register file, single-cycle ALU ops,
// iterative shift-add multiply and illegal-opcode error pulse.
module tiny_cpu_param #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    tiny_cpu_param_if.slave bus
);
    localparam int RB = $clog2(NREGS);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_regs [NREGS];
    logic [WIDTH-1:0]   r_result;
    logic               r_res_valid, r_zero, r_carry, r_err;
    logic [2*WIDTH-1:0] r_mcand, r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [RB-1:0]      r_mul_rd;
    logic [CW-1:0]      r_cnt;

    logic               w_in_ready, w_accept, w_mul_done;
    logic [3:0]         w_op;
    logic [RB-1:0]      w_rd, w_rs;
    logic [WIDTH-1:0]   w_imm, w_a, w_b, w_alu;
    logic               w_alu_c;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign {w_op, w_rd, w_rs, w_imm} = bus.In;
    assign w_a        = r_regs[w_rd];
    assign w_b        = r_regs[w_rs];
    assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
    assign w_accept   = bus.In_valid && w_in_ready;
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
    assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign bus.In_ready  = w_in_ready;
    assign bus.Result    = r_result;
    assign bus.Res_valid = r_res_valid;
    assign bus.Zero      = r_zero;
    assign bus.Carry     = r_carry;
    assign bus.Err       = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.In_valid && (w_op == 4'hC)) w_state_nxt = S_MUL;
            end
            S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu   = '0;
        w_alu_c = 1'b0;
        case (w_op)
            4'h4:    {w_alu_c, w_alu} = w_sum;
            4'h5:    begin w_alu = {w_a[WIDTH-2:0], 1'b0}; w_alu_c = w_a[WIDTH-1]; end
            4'h6:    begin w_alu = {1'b0, w_a[WIDTH-1:1]}; w_alu_c = w_a[0]; end
            4'h7:    w_alu = w_a & w_b;
            4'h8:    w_alu = w_a | w_b;
            4'h9:    w_alu = w_a ^ w_b;
            4'hA:    w_alu = ~(w_a & w_b);
            default: w_alu = '0;
        endcase
    end

    // Operands are read from the register file before this edge's write, so rd == rs is safe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_mul_rd    <= '0;
            r_cnt       <= '0;
        end else begin
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            if (w_accept) begin
                case (w_op)
                    4'h0: begin
                        for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
                        r_result <= '0;
                        r_zero   <= 1'b0;
                        r_carry  <= 1'b0;
                    end
                    4'h1: r_regs[w_rd] <= w_imm;
                    4'h2: r_regs[w_rd] <= w_b;
                    4'h3: r_regs[w_rd] <= r_result;
                    4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
                        r_regs[w_rd] <= w_alu;
                        r_result     <= w_alu;
                        r_zero       <= (w_alu == '0);
                        r_carry      <= w_alu_c;
                        r_res_valid  <= 1'b1;
                    end
                    4'hB: begin
                        r_result    <= (w_a >= w_b) ? '1 : '0;
                        r_carry     <= (w_a >= w_b);
                        r_zero      <= (w_a == w_b);
                        r_res_valid <= 1'b1;
                    end
                    4'hC: begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a};
                        r_mplier <= w_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_mul_rd <= w_rd;
                    end
                    default: r_err <= 1'b1;
                endcase
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_done) begin
                    r_regs[r_mul_rd] <= w_acc_nxt[WIDTH-1:0];
                    r_result         <= w_acc_nxt[WIDTH-1:0];
                    r_carry          <= (w_acc_nxt[2*WIDTH-1:WIDTH] != '0);
                    r_zero           <= (w_acc_nxt[WIDTH-1:0] == '0);
                    r_res_valid      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tiny_cpu_param.sv
// Directed bench for tiny_cpu_param: an 8-bit/4-reg instance and a 16-bit/8-reg instance.
module tb_tiny_cpu_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tiny_cpu_param_if #(.WIDTH(8),  .NREGS(4)) bus8 ();
    tiny_cpu_param_if #(.WIDTH(16), .NREGS(8)) bus16 ();

    tiny_cpu_param #(.WIDTH(8),  .NREGS(4)) dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));
    tiny_cpu_param #(.WIDTH(16), .NREGS(8)) dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus16));

    // Present one instruction for one edge; outputs are then sampled 1 ns after that edge.
    task automatic send8(input logic [3:0] op, input int rd, input int rs, input logic [7:0] imm);
        bus8.In       = {op, 2'(rd), 2'(rs), imm};
        bus8.In_valid = 1'b1;
        @(posedge clk); #1;
        bus8.In_valid = 1'b0;
    endtask

    task automatic send16(input logic [3:0] op, input int rd, input int rs, input logic [15:0] imm);
        bus16.In       = {op, 3'(rd), 3'(rs), imm};
        bus16.In_valid = 1'b1;
        @(posedge clk); #1;
        bus16.In_valid = 1'b0;
    endtask

    task automatic test_reset;
        bus8.In = '0;  bus8.In_valid = 1'b0;
        bus16.In = '0; bus16.In_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({bus8.Result, bus8.Zero, bus8.Carry, bus8.Res_valid, bus8.Err} !== 12'h000) begin
            n_err++; $display("FAIL reset_outputs got %h exp 000",
                              {bus8.Result, bus8.Zero, bus8.Carry, bus8.Res_valid, bus8.Err});
        end
        n_vec++;
        if (bus8.In_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got %b exp 1", bus8.In_ready);
        end
    endtask

    task automatic test_add;
        send8(4'h1, 0, 0, 8'hF0);
        send8(4'h1, 1, 0, 8'h20);
        send8(4'h4, 0, 1, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid} !== {8'h10, 3'b101}) begin
            n_err++; $display("FAIL add got res=%h c=%b z=%b v=%b exp res=10 c=1 z=0 v=1",
                              bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid);
        end
        send8(4'h2, 2, 0, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Res_valid} !== {8'h10, 2'b10}) begin
            n_err++; $display("FAIL add_after_mov got res=%h c=%b v=%b exp res=10 c=1 v=0",
                              bus8.Result, bus8.Carry, bus8.Res_valid);
        end
        send8(4'h8, 2, 2, 8'h00);
        n_vec++;
        if (bus8.Result !== 8'h10) begin
            n_err++; $display("FAIL mov_r2 got %h exp 10", bus8.Result);
        end
    endtask

    task automatic test_shift_logic;
        send8(4'h1, 2, 0, 8'h81);
        send8(4'h5, 2, 0, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero} !== {8'h02, 2'b10}) begin
            n_err++; $display("FAIL shl got res=%h c=%b z=%b exp 02 1 0", bus8.Result, bus8.Carry, bus8.Zero);
        end
        send8(4'h6, 2, 0, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero} !== {8'h01, 2'b00}) begin
            n_err++; $display("FAIL shr got res=%h c=%b z=%b exp 01 0 0", bus8.Result, bus8.Carry, bus8.Zero);
        end
        send8(4'h9, 2, 2, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero} !== {8'h00, 2'b01}) begin
            n_err++; $display("FAIL xor_self got res=%h c=%b z=%b exp 00 0 1", bus8.Result, bus8.Carry, bus8.Zero);
        end
        send8(4'h1, 3, 0, 8'hC3);
        send8(4'hA, 3, 1, 8'h00);
        n_vec++;
        if (bus8.Result !== 8'hFF) begin
            n_err++; $display("FAIL nand got %h exp ff", bus8.Result);
        end
        send8(4'h7, 3, 0, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Zero} !== {8'h10, 1'b0}) begin
            n_err++; $display("FAIL and got res=%h z=%b exp 10 0", bus8.Result, bus8.Zero);
        end
    endtask

    task automatic test_cmp;
        send8(4'h1, 0, 0, 8'h05);
        send8(4'h1, 1, 0, 8'h05);
        send8(4'hB, 0, 1, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid} !== {8'hFF, 3'b111}) begin
            n_err++; $display("FAIL cmp_eq got res=%h c=%b z=%b v=%b exp ff 1 1 1",
                              bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid);
        end
        send8(4'h1, 1, 0, 8'h06);
        send8(4'hB, 0, 1, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero} !== {8'h00, 2'b00}) begin
            n_err++; $display("FAIL cmp_lt got res=%h c=%b z=%b exp 00 0 0", bus8.Result, bus8.Carry, bus8.Zero);
        end
        send8(4'h8, 0, 0, 8'h00);
        n_vec++;
        if (bus8.Result !== 8'h05) begin
            n_err++; $display("FAIL cmp_nowrite got %h exp 05", bus8.Result);
        end
    endtask

    task automatic test_mul;
        int busy;
        logic early_rv;
        send8(4'h1, 0, 0, 8'h13);
        send8(4'h1, 1, 0, 8'h11);
        bus8.In = {4'hC, 2'd0, 2'd1, 8'h00};
        bus8.In_valid = 1'b1;
        @(posedge clk); #1;
        // Next instruction is queued immediately and held while the multiply runs.
        bus8.In = {4'h8, 2'd1, 2'd1, 8'h00};
        busy = 0;
        early_rv = 1'b0;
        while (bus8.In_ready !== 1'b1 && busy < 20) begin
            busy++;
            early_rv |= bus8.Res_valid;
            @(posedge clk); #1;
        end
        n_vec++;
        if (busy != 8) begin
            n_err++; $display("FAIL mul_busy got %0d cycles exp 8", busy);
        end
        n_vec++;
        if (early_rv !== 1'b0) begin
            n_err++; $display("FAIL mul_early_valid got %b exp 0", early_rv);
        end
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid} !== {8'h43, 3'b101}) begin
            n_err++; $display("FAIL mul_13x11 got res=%h c=%b z=%b v=%b exp 43 1 0 1",
                              bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid);
        end
        @(posedge clk); #1;
        bus8.In_valid = 1'b0;
        n_vec++;
        if ({bus8.Result, bus8.Res_valid} !== {8'h11, 1'b1}) begin
            n_err++; $display("FAIL mul_held_accept got res=%h v=%b exp 11 1", bus8.Result, bus8.Res_valid);
        end
        send8(4'h8, 0, 0, 8'h00);
        n_vec++;
        if (bus8.Result !== 8'h43) begin
            n_err++; $display("FAIL mul_rd_write got %h exp 43", bus8.Result);
        end
        send8(4'h1, 2, 0, 8'h0F);
        send8(4'h1, 3, 0, 8'h03);
        send8(4'hC, 2, 3, 8'h00);
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid} !== {8'h2D, 3'b001}) begin
            n_err++; $display("FAIL mul_0fx03 got res=%h c=%b z=%b v=%b exp 2d 0 0 1",
                              bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid);
        end
        send8(4'hC, 3, 3, 8'h00);
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if ({bus8.Result, bus8.Carry} !== {8'h09, 1'b0}) begin
            n_err++; $display("FAIL mul_square got res=%h c=%b exp 09 0", bus8.Result, bus8.Carry);
        end
    endtask

    task automatic test_illegal;
        send8(4'h1, 1, 0, 8'h5A);
        send8(4'h8, 1, 1, 8'h00);
        send8(4'hE, 1, 0, 8'hFF);
        n_vec++;
        if ({bus8.Err, bus8.In_ready, bus8.Res_valid, bus8.Result} !== {3'b110, 8'h5A}) begin
            n_err++; $display("FAIL illegal got err=%b rdy=%b v=%b res=%h exp 1 1 0 5a",
                              bus8.Err, bus8.In_ready, bus8.Res_valid, bus8.Result);
        end
        send8(4'h8, 1, 1, 8'h00);
        n_vec++;
        if ({bus8.Err, bus8.Result} !== {1'b0, 8'h5A}) begin
            n_err++; $display("FAIL illegal_nochange got err=%b res=%h exp 0 5a", bus8.Err, bus8.Result);
        end
    endtask

    task automatic test_clr;
        send8(4'h0, 0, 0, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid} !== 11'h000) begin
            n_err++; $display("FAIL clr got res=%h c=%b z=%b v=%b exp 00 0 0 0",
                              bus8.Result, bus8.Carry, bus8.Zero, bus8.Res_valid);
        end
        send8(4'h8, 1, 1, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Zero} !== {8'h00, 1'b1}) begin
            n_err++; $display("FAIL clr_regs got res=%h z=%b exp 00 1", bus8.Result, bus8.Zero);
        end
    endtask

    task automatic test_wide;
        send16(4'h1, 7, 0, 16'hFFFF);
        send16(4'h4, 7, 7, 16'h0000);
        n_vec++;
        if ({bus16.Result, bus16.Carry, bus16.Zero} !== {16'hFFFE, 2'b10}) begin
            n_err++; $display("FAIL wide_add got res=%h c=%b z=%b exp fffe 1 0", bus16.Result, bus16.Carry, bus16.Zero);
        end
        send16(4'h3, 3, 0, 16'h0000);
        send16(4'h8, 3, 3, 16'h0000);
        n_vec++;
        if ({bus16.Result, bus16.Carry} !== {16'hFFFE, 1'b0}) begin
            n_err++; $display("FAIL wide_sto got res=%h c=%b exp fffe 0", bus16.Result, bus16.Carry);
        end
    endtask

    task automatic test_reset_mid_mul;
        send8(4'h1, 2, 0, 8'h0F);
        send8(4'h1, 3, 0, 8'h03);
        send8(4'h8, 3, 3, 8'h00);
        send8(4'hC, 2, 3, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus8.Result, bus8.Zero, bus8.Carry, bus8.Res_valid, bus8.Err} !== 12'h000) begin
            n_err++; $display("FAIL rst_mid_mul got %h exp 000",
                              {bus8.Result, bus8.Zero, bus8.Carry, bus8.Res_valid, bus8.Err});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send8(4'h8, 2, 2, 8'h00);
        n_vec++;
        if ({bus8.Result, bus8.Zero} !== {8'h00, 1'b1}) begin
            n_err++; $display("FAIL rst_mid_mul_regs got res=%h z=%b exp 00 1", bus8.Result, bus8.Zero);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift_logic();
        test_cmp();
        test_mul();
        test_illegal();
        test_clr();
        test_wide();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tiny_cpu_param.md
Name: tiny_cpu_param

Overview:
- Parametrised successor to the 8-bit two-register tiny CPU.
- Adds a generic-width datapath, an NREGS-entry register file addressed by the instruction, and a valid/ready instruction handshake.
- Adds Zero/Carry flags, an iterative multi-cycle multiply, and an error flag for illegal opcodes.
- Sits between an instruction source (testbench, switch panel or sequencer) and a result display/consumer.

Parameters:
- WIDTH, 8: datapath and register width in bits; must be >= 2.
- NREGS, 4: register file depth; power of 2, >= 2. RB = clog2(NREGS).
- IW (derived, not overridable): instruction width = 4 + 2*RB + WIDTH.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- In  in  IW  instruction = {op[3:0], rd[RB-1:0], rs[RB-1:0], imm[WIDTH-1:0]}, MSB first.
- In_valid  in  1  In holds an instruction.
- In_ready  out  1  block can accept; an instruction is accepted on a rising Clk edge where In_valid && In_ready.
- Result  out  WIDTH  output register; holds the last ALU result.
- Res_valid  out  1  one-cycle pulse when Result is written.
- Zero  out  1  flag: last ALU result == 0.
- Carry  out  1  flag: carry/borrow/shift-out, per opcode below.
- Err  out  1  one-cycle pulse when an illegal opcode is accepted.

Behaviour:
- Reset (Rst_n low, asynchronous): R[0..NREGS-1], Result, Zero, Carry, Res_valid and Err = 0; FSM -> IDLE; In_ready = 1 after release. Reset during MUL aborts it; no write occurs.
- FSM states: IDLE and MUL. In_ready = 1 in IDLE and 0 in MUL.
- Single-cycle ops: complete at the accepting edge. R[rd], Result and flags are visible the next cycle. Res_valid pulses in the following cycle for ALU ops only.
- Opcode map (all arithmetic modulo 2^WIDTH, unsigned):
  - 0 CLR: all R, Result and flags := 0; Res_valid stays 0.
  - 1 LDI: R[rd] := imm.
  - 2 MOV: R[rd] := R[rs].
  - 3 STO: R[rd] := Result.
  - Ops 1-3 leave Result and flags unchanged.
  - 4 ADD: R[rd] := R[rd] + R[rs]; Carry = carry-out.
  - 5 SHL: R[rd] := R[rd] << 1; Carry = old MSB.
  - 6 SHR: R[rd] := R[rd] >> 1 (logical); Carry = old LSB.
  - 7 AND, 8 OR, 9 XOR, A NAND: R[rd] := R[rd] op R[rs]; Carry = 0.
  - B CMP: no register write; Result := all-ones if R[rd] >= R[rs], else 0; Carry = (R[rd] >= R[rs]); Zero = (R[rd] == R[rs]).
  - C MUL: multi-cycle (see below).
  - D-F: illegal. Err pulses; no state change; In_ready stays 1.
- For ops 4-A: Result := new R[rd] value; Zero = (that value == 0).
- MUL detail:
  - The accepting edge latches operands and moves IDLE -> MUL.
  - Shift-add runs one bit per cycle for exactly WIDTH cycles.
  - At the WIDTH-th edge after acceptance: R[rd] := low WIDTH bits of the product; Result := same value; Carry = (high half != 0); Zero = (low half == 0); Res_valid pulses; FSM -> IDLE.
  - Throughput: WIDTH+1 cycles per MUL, from acceptance to next acceptance.
- rd == rs: operands are read before the write (ADD doubles, XOR yields 0, MUL squares).
- In_valid while In_ready = 0: ignored; the source must hold In stable until accepted.
- Back-to-back single-cycle ops: accepted every cycle; each sees the prior op's register writes (no hazard stalls).

Test Plan:
- Reset then idle, WIDTH=8 -> Result=0x00, Zero=0, Carry=0, In_ready=1; Rst_n low mid-MUL -> all outputs 0 immediately.
- Add with carry: LDI r0,0xF0; LDI r1,0x20; ADD r0,r1 -> r0=Result=0x10, Carry=1, Zero=0, one Res_valid pulse.
- Shift/logic: LDI r2,0x81; SHL r2 -> 0x02, Carry=1; SHR r2 -> 0x01, Carry=0; XOR r2,r2 -> 0x00, Zero=1.
- Compare: r0=0x05, r1=0x05; CMP r0,r1 -> Result=0xFF, Carry=1, Zero=1; with r1=0x06 -> Result=0x00, Carry=0, Zero=0.
- Multiply: r0=0x13, r1=0x11; MUL r0,r1 -> In_ready low 8 cycles; Result=0x43, Carry=1 at edge 8. Repeat 0x0F*0x03 -> 0x2D, Carry=0. A held In_valid is accepted on the first cycle back in IDLE.
- Illegal and parametrised: opcode 0xE -> Err pulse, registers unchanged. Rebuild with WIDTH=16, NREGS=8: LDI r7,0xFFFF; ADD r7,r7 -> 0xFFFE, Carry=1; STO r3 -> r3=0xFFFE.
